// File: rtl/button_debouncer_array.sv
// button_debouncer_array: per-channel synchronised debouncer with press/release pulses and optional auto-repeat
module button_debouncer_array #(
    parameter int NUM_BTNS        = 4,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter bit ACTIVE_LOW      = 1,
    parameter bit REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 2**22,
    parameter int REPEAT_PERIOD   = 2**20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_state,
    output logic [NUM_BTNS-1:0] btn_down,
    output logic [NUM_BTNS-1:0] btn_up,
    output logic [NUM_BTNS-1:0] btn_repeat
);
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        logic sync0, sync1, state, down, up, flip;
        logic [CW-1:0] cnt;
        assign flip = sync1 != state && cnt == CW'(DEBOUNCE_CYCLES - 1);
        assign btn_state[i] = state;
        assign btn_down[i]  = down;
        assign btn_up[i]    = up;
        always_ff @(posedge clk) begin
            if (rst) begin
                sync0 <= 1'b0;
                sync1 <= 1'b0;
                cnt   <= '0;
                state <= 1'b0;
                down  <= 1'b0;
                up    <= 1'b0;
            end else begin
                sync0 <= ACTIVE_LOW ? ~btn_raw[i] : btn_raw[i];
                sync1 <= sync0;
                cnt   <= (sync1 == state || flip) ? '0 : cnt + 1'b1;
                state <= state ^ flip;
                down  <= flip & ~state;
                up    <= flip & state;
            end
        end
        if (REPEAT_EN) begin : g_rep
            typedef enum logic [1:0] {IDLE, FIRST, PERIODIC} rstate_t;
            rstate_t rs;
            logic [RW-1:0] rcnt;
            logic rep, hit;
            assign hit = (rs == FIRST && rcnt == RW'(REPEAT_DELAY - 1)) ||
                         (rs == PERIODIC && rcnt == RW'(REPEAT_PERIOD - 1));
            assign btn_repeat[i] = rep;
            // a falling edge wins over a due pulse so repeat never lands on btn_up
            always_ff @(posedge clk) begin
                if (rst || (flip && state)) begin
                    rs   <= IDLE;
                    rcnt <= '0;
                    rep  <= 1'b0;
                end else if (flip) begin
                    rs   <= FIRST;
                    rcnt <= '0;
                    rep  <= 1'b0;
                end else begin
                    rep  <= hit;
                    rcnt <= (rs == IDLE || hit) ? '0 : rcnt + 1'b1;
                    rs   <= hit ? PERIODIC : rs;
                end
            end
        end else begin : g_norep
            assign btn_repeat[i] = 1'b0;
        end
    end
endmodule

// File: tb/tb_button_debouncer_array.sv
// tb_button_debouncer_array: directed and random checks against a sample-window reference model
module tb_button_debouncer_array;
    localparam int N = 2, D = 4, RD = 8, RP = 3;
    logic clk = 1'b0, rst = 1'b1;
    logic [N-1:0] btn_raw = '1;
    logic [N-1:0] btn_state, btn_down, btn_up, btn_repeat;
    logic [N-1:0] e_state = '0, e_down = '0, e_up = '0, e_rep = '0;
    bit hist [N][D+2];
    int td [N];
    int total = 0, bad = 0, cyc = 0;

    button_debouncer_array #(
        .NUM_BTNS(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1),
        .REPEAT_EN(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_state(btn_state),
        .btn_down(btn_down), .btn_up(btn_up), .btn_repeat(btn_repeat)
    );

    always #5 clk = ~clk;

    // state flips once D consecutive synchronised samples (two edges old) all differ from it
    task automatic tick();
        @(posedge clk);
        cyc++;
        for (int c = 0; c < N; c++) begin
            bit diff;
            if (rst) begin
                for (int j = 0; j < D + 2; j++) hist[c][j] = 1'b0;
                e_state[c] = 1'b0; e_down[c] = 1'b0; e_up[c] = 1'b0; e_rep[c] = 1'b0;
            end else begin
                for (int j = D + 1; j > 0; j--) hist[c][j] = hist[c][j-1];
                hist[c][0] = ~btn_raw[c];
                diff = 1'b1;
                for (int j = 2; j <= D + 1; j++) if (hist[c][j] == e_state[c]) diff = 1'b0;
                e_down[c] = diff && !e_state[c];
                e_up[c]   = diff && e_state[c];
                if (diff) e_state[c] = !e_state[c];
                if (e_down[c]) td[c] = cyc;
                e_rep[c] = e_state[c] && !e_down[c] && (cyc - td[c]) >= RD && (cyc - td[c] - RD) % RP == 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        total++;
        if ({btn_state, btn_down, btn_up, btn_repeat} !== '0) begin
            bad++;
            $display("FAIL reset got=%b exp=0", {btn_state, btn_down, btn_up, btn_repeat});
        end
        rst = 1'b0;
    endtask

    task automatic test_press();
        btn_raw[0] = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            total++;
            if ({btn_state, btn_down, btn_up, btn_repeat} !== {e_state, e_down, e_up, e_rep}) begin
                bad++;
                $display("FAIL press_model k=%0d got=%b exp=%b", k, {btn_state, btn_down, btn_up, btn_repeat}, {e_state, e_down, e_up, e_rep});
            end
            total++;
            if (btn_down[0] !== (k == 6) || btn_state[0] !== (k >= 6) || btn_up !== '0 || btn_state[1] !== 1'b0) begin
                bad++;
                $display("FAIL press_timing k=%0d state=%b down=%b up=%b", k, btn_state, btn_down, btn_up);
            end
        end
    endtask

    task automatic test_release();
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            total++;
            if ({btn_state, btn_down, btn_up, btn_repeat} !== {e_state, e_down, e_up, e_rep}) begin
                bad++;
                $display("FAIL release_model k=%0d got=%b exp=%b", k, {btn_state, btn_down, btn_up, btn_repeat}, {e_state, e_down, e_up, e_rep});
            end
            total++;
            if (btn_up[0] !== (k == 6) || btn_state[0] !== (k < 6)) begin
                bad++;
                $display("FAIL release_timing k=%0d state=%b up=%b exp_up=%b", k, btn_state[0], btn_up[0], k == 6);
            end
        end
    endtask

    task automatic test_bounce();
        int downs = 0;
        for (int k = 1; k <= 14; k++) begin
            btn_raw[0] = (k <= 4) ? ((k % 2 == 1) ? 1'b0 : 1'b1) : 1'b0;
            tick();
            downs += btn_down[0];
            total++;
            if ({btn_state, btn_down, btn_up, btn_repeat} !== {e_state, e_down, e_up, e_rep}) begin
                bad++;
                $display("FAIL bounce_model k=%0d got=%b exp=%b", k, {btn_state, btn_down, btn_up, btn_repeat}, {e_state, e_down, e_up, e_rep});
            end
            total++;
            if (btn_state[0] !== (k >= 10)) begin
                bad++;
                $display("FAIL bounce_timing k=%0d state=%b exp=%b", k, btn_state[0], k >= 10);
            end
        end
        total++;
        if (downs != 1) begin
            bad++;
            $display("FAIL bounce_downs got=%0d exp=1", downs);
        end
    endtask

    task automatic test_repeat();
        int kd = -100;
        int offs [$];
        int exp_offs [$] = '{8, 11, 14, 17, 20};
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 8; k++) tick();
        btn_raw[0] = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            tick();
            if (btn_down[0]) kd = k;
            if (btn_repeat[0]) offs.push_back(k - kd);
            total++;
            if ({btn_state, btn_down, btn_up, btn_repeat} !== {e_state, e_down, e_up, e_rep}) begin
                bad++;
                $display("FAIL repeat_model k=%0d got=%b exp=%b", k, {btn_state, btn_down, btn_up, btn_repeat}, {e_state, e_down, e_up, e_rep});
            end
        end
        total++;
        if (offs != exp_offs) begin
            bad++;
            $display("FAIL repeat_offsets got=%p exp=%p", offs, exp_offs);
        end
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            total++;
            if ((btn_repeat[0] & btn_up[0]) !== 1'b0 || btn_up[0] !== (k == 6)) begin
                bad++;
                $display("FAIL repeat_release k=%0d up=%b rep=%b", k, btn_up[0], btn_repeat[0]);
            end
            total++;
            if ({btn_state, btn_down, btn_up, btn_repeat} !== {e_state, e_down, e_up, e_rep}) begin
                bad++;
                $display("FAIL repeat_rel_model k=%0d got=%b exp=%b", k, {btn_state, btn_down, btn_up, btn_repeat}, {e_state, e_down, e_up, e_rep});
            end
        end
    endtask

    task automatic test_reset_mid();
        btn_raw[0] = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        rst = 1'b1;
        tick();
        total++;
        if ({btn_state, btn_down, btn_up, btn_repeat} !== '0) begin
            bad++;
            $display("FAIL reset_mid got=%b exp=0", {btn_state, btn_down, btn_up, btn_repeat});
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            total++;
            if (btn_down[0] !== (k == 6) || {btn_state, btn_down, btn_up, btn_repeat} !== {e_state, e_down, e_up, e_rep}) begin
                bad++;
                $display("FAIL reset_redetect k=%0d got=%b exp=%b", k, {btn_state, btn_down, btn_up, btn_repeat}, {e_state, e_down, e_up, e_rep});
            end
        end
    endtask

    task automatic test_both();
        btn_raw = '1;
        for (int k = 1; k <= 8; k++) tick();
        btn_raw = '0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            total++;
            if (btn_down !== ((k == 6) ? 2'b11 : 2'b00) || {btn_state, btn_down, btn_up, btn_repeat} !== {e_state, e_down, e_up, e_rep}) begin
                bad++;
                $display("FAIL both_down k=%0d down=%b got=%b exp=%b", k, btn_down, {btn_state, btn_down, btn_up, btn_repeat}, {e_state, e_down, e_up, e_rep});
            end
        end
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            btn_raw[1] = 1'($urandom_range(0, 1));
            tick();
            total++;
            if ({btn_state, btn_down, btn_up, btn_repeat} !== {e_state, e_down, e_up, e_rep}) begin
                bad++;
                $display("FAIL both_indep k=%0d got=%b exp=%b", k, {btn_state, btn_down, btn_up, btn_repeat}, {e_state, e_down, e_up, e_rep});
            end
        end
        btn_raw = '1;
        for (int k = 1; k <= 8; k++) tick();
    endtask

    task automatic test_random();
        for (int k = 1; k <= 600; k++) begin
            rst = ($urandom_range(0, 149) == 0);
            for (int c = 0; c < N; c++) if ($urandom_range(0, 5) == 0) btn_raw[c] = ~btn_raw[c];
            tick();
            total++;
            if ({btn_state, btn_down, btn_up, btn_repeat} !== {e_state, e_down, e_up, e_rep}) begin
                bad++;
                $display("FAIL random k=%0d got=%b exp=%b", k, {btn_state, btn_down, btn_up, btn_repeat}, {e_state, e_down, e_up, e_rep});
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_repeat();
        test_reset_mid();
        test_both();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
